up_down_counter_mod: RTL and testbench

Parametrised successor to the 4-bit up/down counter: a WIDTH-bit up/down counter with a run-time programmable modulus limit, programmable step, wrap or saturate mode, synchronous load, and registered overflow/underflow reporting. It serves as the general-purpose counter primitive for timers, address generators and event counting. All state is held in one clock domain.

---
 rtl/up_down_counter_mod.sv | 111 +++++++++++
 tb/tb_up_down_counter_mod.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter_mod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | up_down_counter_mod: WIDTH-bit up/down counter, programmable limit/step,  |
// | wrap or saturate, synchronous load, sticky overflow/underflow. Rev 1.0    |
// +--------------------------------------------------------------------------+
module up_down_counter_mod #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             set,
  input  logic [WIDTH-1:0] set_value,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             saturate,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap_pulse,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] w_reset_val;
  logic [WIDTH-1:0] w_step_eff;
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_step_x;
  logic [WIDTH:0]   w_lim_x;
  logic [WIDTH:0]   w_mod_x;
  logic [WIDTH:0]   w_sum_x;
  logic [WIDTH:0]   w_up_wrap_x;
  logic [WIDTH:0]   w_dn_wrap_x;
  logic             w_up_event;
  logic             w_dn_event;

  assign w_reset_val = WIDTH'(RESET_VALUE);
  assign w_step_eff  = (step > limit) ? limit : step;

  // All range arithmetic is one bit wider so count+step never truncates.
  assign w_cnt_x     = {1'b0, count_q};
  assign w_step_x    = {1'b0, w_step_eff};
  assign w_lim_x     = {1'b0, limit};
  assign w_mod_x     = w_lim_x + {{WIDTH{1'b0}}, 1'b1};
  assign w_sum_x     = w_cnt_x + w_step_x;
  assign w_up_wrap_x = w_sum_x - w_mod_x;
  assign w_dn_wrap_x = w_cnt_x + w_mod_x - w_step_x;
  assign w_up_event  = w_sum_x > w_lim_x;
  assign w_dn_event  = w_step_x > w_cnt_x;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clear_flags;
    unf_d   = unf_q & ~clear_flags;
    if (set) begin
      count_d = (set_value > limit) ? limit : set_value;
    end else if (count_q > limit) begin
      count_d = limit;
    end else if (enable) begin
      if (up_down) begin
        if (w_up_event) begin
          count_d = saturate ? limit : w_up_wrap_x[WIDTH-1:0];
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = w_sum_x[WIDTH-1:0];
        end
      end else begin
        if (w_dn_event) begin
          count_d = saturate ? '0 : w_dn_wrap_x[WIDTH-1:0];
          wrap_d  = 1'b1;
          unf_d   = 1'b1;
        end else begin
          count_d = count_q - w_step_eff;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= (w_reset_val > limit) ? limit : w_reset_val;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count      = count_q;
  assign at_max     = (count_q == limit);
  assign at_zero    = (count_q == '0);
  assign wrap_pulse = wrap_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_up_down_counter_mod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_up_down_counter_mod: directed stimulus, reference model, literal pins. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_up_down_counter_mod;

  localparam int WIDTH = 4;
  localparam int RESET_VALUE = 0;

  logic             clk = 1'b0;
  logic             reset, enable, set, up_down, saturate, clear_flags;
  logic [WIDTH-1:0] set_value, step, limit;
  logic [WIDTH-1:0] count;
  logic             at_max, at_zero, wrap_pulse, overflow, underflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int m_count = 0;
  bit m_wp = 1'b0, m_ov = 1'b0, m_un = 1'b0;

  up_down_counter_mod #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) dut (
    .clk(clk), .reset(reset), .enable(enable), .set(set), .set_value(set_value),
    .up_down(up_down), .step(step), .limit(limit), .saturate(saturate),
    .clear_flags(clear_flags), .count(count), .at_max(at_max), .at_zero(at_zero),
    .wrap_pulse(wrap_pulse), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: range arithmetic on plain integers, wrap via modulo.
  always @(posedge clk) begin
    automatic int lim = int'(limit);
    automatic int nc = m_count;
    automatic int s = (int'(step) < lim) ? int'(step) : lim;
    automatic bit eo = 1'b0, eu = 1'b0;
    if (reset) begin
      m_count <= (RESET_VALUE < lim) ? RESET_VALUE : lim;
      m_wp <= 1'b0; m_ov <= 1'b0; m_un <= 1'b0;
    end else begin
      if (set) nc = (int'(set_value) < lim) ? int'(set_value) : lim;
      else if (m_count > lim) nc = lim;
      else if (enable) begin
        if (up_down) begin
          eo = (m_count + s) > lim;
          nc = (eo && saturate) ? lim : (m_count + s) % (lim + 1);
        end else begin
          eu = s > m_count;
          nc = (eu && saturate) ? 0 : (m_count - s + lim + 1) % (lim + 1);
        end
      end
      m_count <= nc;
      m_wp <= eo | eu;
      m_ov <= eo | (m_ov & ~clear_flags);
      m_un <= eu | (m_un & ~clear_flags);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("model.count", int'(count), m_count);
      chk("model.at_max", int'(at_max), int'(m_count == int'(limit)));
      chk("model.at_zero", int'(at_zero), int'(m_count == 0));
      chk("model.wrap_pulse", int'(wrap_pulse), int'(m_wp));
      chk("model.overflow", int'(overflow), int'(m_ov));
      chk("model.underflow", int'(underflow), int'(m_un));
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; set = 1'b0; set_value = '0; up_down = 1'b1;
    step = 4'd1; limit = 4'd9; saturate = 1'b0; clear_flags = 1'b0;
    nxt();
    chk_en = 1'b1;
    nxt();
    reset = 1'b0;
    nxt();
    chk("rst.count", int'(count), 0);
    chk("rst.at_zero", int'(at_zero), 1);
    chk("rst.flags", int'({wrap_pulse, overflow, underflow}), 0);

    // Up, wrap, limit 9
    set = 1'b1; set_value = 4'd8; nxt();
    chk("wrapup.load", int'(count), 8);
    set = 1'b0; enable = 1'b1; nxt();
    chk("wrapup.c9", int'(count), 9);
    chk("wrapup.at_max", int'(at_max), 1);
    chk("wrapup.wp_pre", int'(wrap_pulse), 0);
    nxt();
    chk("wrapup.c0", int'(count), 0);
    chk("wrapup.wp", int'(wrap_pulse), 1);
    chk("wrapup.ovf", int'(overflow), 1);
    nxt();
    chk("wrapup.c1", int'(count), 1);
    chk("wrapup.wp_post", int'(wrap_pulse), 0);

    // Down, saturate, step 3
    enable = 1'b0; set = 1'b1; set_value = 4'd4; up_down = 1'b0;
    step = 4'd3; saturate = 1'b1; nxt();
    set = 1'b0; enable = 1'b1; nxt();
    chk("satdn.c1", int'(count), 1);
    chk("satdn.wp0", int'(wrap_pulse), 0);
    nxt();
    chk("satdn.c0a", int'(count), 0);
    chk("satdn.wp1", int'(wrap_pulse), 1);
    chk("satdn.unf", int'(underflow), 1);
    nxt();
    chk("satdn.c0b", int'(count), 0);
    chk("satdn.wp2", int'(wrap_pulse), 1);
    enable = 1'b0; nxt();
    chk("satdn.wp_end", int'(wrap_pulse), 0);

    // Load clipped to limit, then limit lowered
    set = 1'b1; set_value = 4'd13; nxt();
    chk("setclip.c", int'(count), 9);
    set = 1'b0; limit = 4'd5; nxt();
    chk("clamp.c", int'(count), 5);
    chk("clamp.flags", int'({overflow, underflow}), 3);

    // Set beats enable; clear vs. new event; clear alone
    set = 1'b1; enable = 1'b1; up_down = 1'b1; saturate = 1'b0;
    set_value = 4'd2; step = 4'd4; nxt();
    chk("setwin.c", int'(count), 2);
    set = 1'b0; clear_flags = 1'b1; nxt();
    chk("clrev.c", int'(count), 0);
    chk("clrev.ovf", int'(overflow), 1);
    chk("clrev.unf", int'(underflow), 0);
    enable = 1'b0; nxt();
    chk("clr.ovf", int'(overflow), 0);
    clear_flags = 1'b0;

    // Reset mid-count
    limit = 4'd9; step = 4'd1; set = 1'b1; set_value = 4'd7; nxt();
    set = 1'b0; enable = 1'b1; reset = 1'b1; nxt();
    chk("midrst.c", int'(count), 0);
    chk("midrst.wp", int'(wrap_pulse), 0);
    reset = 1'b0; nxt();
    chk("resume.c1", int'(count), 1);
    nxt();
    chk("resume.c2", int'(count), 2);

    // Step larger than limit is reduced to limit
    step = 4'd15; set = 1'b1; set_value = 4'd0; nxt();
    set = 1'b0; nxt();
    chk("bigstep.c9", int'(count), 9);
    nxt();
    chk("bigstep.c8", int'(count), 8);
    up_down = 1'b0; nxt();
    chk("bigstep.dnwrap", int'(count), 9);
    chk("bigstep.unf", int'(underflow), 1);

    // limit = 0 forces count to 0 and blocks events
    limit = 4'd0; step = 4'd3; nxt();
    chk("lim0.clamp", int'(count), 0);
    nxt();
    chk("lim0.hold", int'(count), 0);
    chk("lim0.wp", int'(wrap_pulse), 0);

    // Saturate up at max
    limit = 4'd6; saturate = 1'b1; up_down = 1'b1; step = 4'd2;
    set = 1'b1; set_value = 4'd6; nxt();
    set = 1'b0; clear_flags = 1'b0; nxt();
    chk("satmax.c", int'(count), 6);
    chk("satmax.wp", int'(wrap_pulse), 1);

    enable = 1'b0;
    nxt();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
